// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/multi-cycle hazard control, operand forwarding and saturating event counters
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_mc,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic              mc_start, mc_stall, load_use, br;

  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] rs);
    return (mem_regwrite && mem_rd != '0 && mem_rd == rs) ? 2'b10 :
           (wb_regwrite && wb_rd != '0 && wb_rd == rs) ? 2'b01 : 2'b00;
  endfunction

  assign mc_start = state_q == IDLE && ex_valid && ex_mc;
  assign mc_stall = mc_start || (state_q == BUSY && cnt_q != 8'd0);
  assign load_use = ex_valid && ex_memread && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign br = !mc_stall && branch_taken;

  // Reset forces the front end frozen and the pipe flushed, independent of inputs
  assign pc_write      = !rst && !mc_stall && (branch_taken || !load_use);
  assign if_id_write   = pc_write;
  assign if_id_flush   = rst || br;
  assign id_ex_write   = rst || !mc_stall;
  assign id_ex_bubble  = rst || br || (!mc_stall && load_use);
  assign ex_mem_bubble = rst || mc_stall;
  assign forward_a     = rst ? 2'b00 : fwd(ex_rs1);
  assign forward_b     = rst ? 2'b00 : fwd(ex_rs2);
  assign mc_busy       = state_q == BUSY;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;

  always_comb begin
    state_d = mc_start ? BUSY : (state_q == BUSY && cnt_q == 8'd0) ? IDLE : state_q;
    cnt_d   = mc_start ? 8'(MC_LAT - 2) : (state_q == BUSY && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    stall_d = stall_q + CNT_W'(!pc_write && stall_q != '1);
    flush_d = flush_q + CNT_W'(if_id_flush && flush_q != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard checked by a separate monitor
module tb_pipe_hazard_ctrl;
  logic clk = 1'b1, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_valid, ex_memread, ex_mc, ex_mc2, branch_taken, mem_regwrite, wb_regwrite;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_busy;
  logic [1:0] forward_a, forward_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic p2, iw2, fl2, iew2, bub2, emb2, b2;
  logic [1:0] fa2, fb2;
  logic [3:0] s2, f2;

  localparam logic [5:0] NRM = 6'b110100, LU = 6'b000110, BR = 6'b111110, MC = 6'b000001, RS = 6'b001111;

  typedef struct packed {
    logic [5:0] ctl; logic [1:0] fa, fb; logic busy;
    logic [15:0] sc, fc; logic p2, b2; logic [3:0] s2;
  } exp_t;
  exp_t q[$];
  int es = 0, efc = 0, es2 = 0, total = 0, pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mc(ex_mc),
    .branch_taken(branch_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .forward_a(forward_a), .forward_b(forward_b),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_ctrl #(.MC_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mc(ex_mc2),
    .branch_taken(branch_taken), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(p2), .if_id_write(iw2), .if_id_flush(fl2), .id_ex_write(iew2),
    .id_ex_bubble(bub2), .ex_mem_bubble(emb2), .forward_a(fa2), .forward_b(fb2),
    .mc_busy(b2), .stall_cnt(s2), .flush_cnt(f2));

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
    total++;
    if (a === x) pass++;
    else $display("FAIL %s: got %h want %h at %0t", n, a, x, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ctl", {10'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble}, {10'd0, e.ctl});
      chk("forward_a", {14'd0, forward_a}, {14'd0, e.fa});
      chk("forward_b", {14'd0, forward_b}, {14'd0, e.fb});
      chk("mc_busy", {15'd0, mc_busy}, {15'd0, e.busy});
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
      chk("pc_write2", {15'd0, p2}, {15'd0, e.p2});
      chk("mc_busy2", {15'd0, b2}, {15'd0, e.b2});
      chk("stall_cnt2", {12'd0, s2}, {12'd0, e.s2});
    end
  end

  task automatic push(input logic [5:0] c, input logic [1:0] a, input logic [1:0] b, input logic bz,
                      input logic pp, input logic bb);
    exp_t e;
    e.ctl = c; e.fa = a; e.fb = b; e.busy = bz; e.sc = 16'(es); e.fc = 16'(efc);
    e.p2 = pp; e.b2 = bb; e.s2 = 4'(es2);
    q.push_back(e);
  endtask

  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_valid, ex_memread, ex_mc, ex_mc2, branch_taken, mem_regwrite, wb_regwrite} = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lu();
    clr();
    ex_valid = 1; ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  initial begin
    rst = 1; clr();
    ex_valid = 1; ex_mc = 1; ex_mc2 = 1; branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    mem_rd = 7; mem_regwrite = 1; ex_rs1 = 7;
    #1 push(RS, 0, 0, 0, 0, 0);
    cyc(); push(RS, 0, 0, 0, 0, 0);
    cyc(); rst = 0; clr(); push(NRM, 0, 0, 0, 1, 0);
    cyc(); lu(); push(LU, 0, 0, 0, 0, 0); es++; es2++;
    cyc(); ex_rd = 0; id_rs2 = 0; push(NRM, 0, 0, 0, 1, 0);
    cyc(); ex_rd = 5; id_rs2 = 5; ex_valid = 0; push(NRM, 0, 0, 0, 1, 0);
    cyc(); clr(); ex_valid = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    push(LU, 0, 0, 0, 0, 0); es++; es2++;
    cyc(); branch_taken = 1; push(BR, 0, 0, 0, 1, 0); efc++;
    cyc(); clr(); ex_valid = 1; ex_rs1 = 7; ex_rs2 = 7; mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1;
    push(NRM, 2'b10, 2'b10, 0, 1, 0);
    cyc(); mem_regwrite = 0; push(NRM, 2'b01, 2'b01, 0, 1, 0);
    cyc(); mem_regwrite = 1; {ex_rs1, ex_rs2, mem_rd, wb_rd} = '0; push(NRM, 0, 0, 0, 1, 0);
    cyc(); ex_rs1 = 3; ex_rs2 = 9; mem_rd = 9; wb_rd = 3; push(NRM, 2'b01, 2'b10, 0, 1, 0);
    cyc(); mem_rd = 3; wb_regwrite = 0; push(NRM, 2'b10, 2'b00, 0, 1, 0);
    cyc(); clr(); ex_valid = 1; ex_mc = 1; push(MC, 0, 0, 0, 1, 0); es++;
    cyc(); branch_taken = 1; push(MC, 0, 0, 1, 1, 0); es++;
    cyc(); branch_taken = 0; push(MC, 0, 0, 1, 1, 0); es++;
    cyc(); push(NRM, 0, 0, 1, 1, 0);
    cyc(); push(MC, 0, 0, 0, 1, 0); es++;
    cyc(); push(MC, 0, 0, 1, 1, 0); es++;
    cyc(); es = 0; efc = 0; es2 = 0; push(RS, 0, 0, 0, 0, 0); #2 rst = 1;
    cyc(); push(RS, 0, 0, 0, 0, 0);
    cyc(); rst = 0; push(MC, 0, 0, 0, 1, 0); es++;
    cyc(); push(MC, 0, 0, 1, 1, 0); es++;
    cyc(); push(MC, 0, 0, 1, 1, 0); es++;
    cyc(); push(NRM, 0, 0, 1, 1, 0);
    cyc(); clr(); push(NRM, 0, 0, 0, 1, 0);
    cyc(); ex_valid = 1; ex_mc2 = 1; push(NRM, 0, 0, 0, 0, 0); es2++;
    cyc(); push(NRM, 0, 0, 0, 1, 1);
    cyc(); clr(); push(NRM, 0, 0, 0, 1, 0);
    cyc(); rst = 1; es = 0; efc = 0; es2 = 0; push(RS, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); rst = 0; lu(); push(LU, 0, 0, 0, 0, 0);
      es++; es2 = (es2 < 15) ? es2 + 1 : 15;
    end
    cyc(); clr(); push(NRM, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    total++;
    if (q.size() == 0) pass++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
